// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and stall signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data stages;
// each access runs a fixed-latency issue/wait/respond sequence.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input logic               clock,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state, state_nx;
    owner_t      owner, owner_nx, last_grant, last_grant_nx, pick;
    logic [3:0]  cnt, cnt_nx;
    logic        we_q, we_nx;
    logic [31:0] addr_nx, wdata_nx, if_rdata_nx, dm_rdata_nx;
    logic        mem_en_nx, mem_we_nx, if_ready_nx, dm_ready_nx;
    logic        capture;

    assign bus.stall_f = bus.if_req & ~bus.if_ready;
    assign bus.stall_m = bus.dm_req & ~bus.dm_ready;

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        we_nx         = we_q;
        addr_nx       = bus.mem_addr;
        wdata_nx      = bus.mem_wdata;
        if_rdata_nx   = bus.if_rdata;
        dm_rdata_nx   = bus.dm_rdata;
        mem_en_nx     = 1'b0;
        mem_we_nx     = 1'b0;
        if_ready_nx   = 1'b0;
        dm_ready_nx   = 1'b0;
        capture       = 1'b0;

        // With both pending, the one not granted last time wins.
        if (bus.if_req && bus.dm_req)
            pick = (last_grant == OWN_IF) ? OWN_DM : OWN_IF;
        else
            pick = bus.dm_req ? OWN_DM : OWN_IF;

        case (state)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_nx      = ISSUE;
                    owner_nx      = pick;
                    last_grant_nx = pick;
                    cnt_nx        = CNT_INIT;
                    mem_en_nx     = 1'b1;
                    if (pick == OWN_DM) begin
                        addr_nx   = bus.dm_addr;
                        wdata_nx  = bus.dm_wdata;
                        we_nx     = bus.dm_we;
                        mem_we_nx = bus.dm_we;
                    end else begin
                        addr_nx   = bus.if_addr;
                        wdata_nx  = '0;
                        we_nx     = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                    capture  = ~we_q;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = RESP;
                    capture  = ~we_q;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Ready is registered, so it is raised on the edge that enters RESP.
        if (state_nx == RESP) begin
            if_ready_nx = (owner == OWN_IF);
            dm_ready_nx = (owner == OWN_DM);
        end
        if (capture) begin
            if (owner == OWN_DM) dm_rdata_nx = bus.mem_rdata;
            else                 if_rdata_nx = bus.mem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            last_grant    <= OWN_IF;
            cnt           <= '0;
            we_q          <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
            bus.if_ready  <= 1'b0;
            bus.dm_ready  <= 1'b0;
        end else begin
            state         <= state_nx;
            owner         <= owner_nx;
            last_grant    <= last_grant_nx;
            cnt           <= cnt_nx;
            we_q          <= we_nx;
            bus.mem_addr  <= addr_nx;
            bus.mem_wdata <= wdata_nx;
            bus.mem_en    <= mem_en_nx;
            bus.mem_we    <= mem_we_nx;
            bus.if_rdata  <= if_rdata_nx;
            bus.dm_rdata  <= dm_rdata_nx;
            bus.if_ready  <= if_ready_nx;
            bus.dm_ready  <= dm_ready_nx;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single-ported backing memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) in the pipelined MIPS core. It serializes the two requesters with a round-robin grant and runs each access through a fixed-latency issue/wait/respond sequence. It returns read data with a one-cycle ready pulse and produces the `stall_f` / `stall_m` signals that hold the pipeline while an access is outstanding.

## Interface

Parameters:
- `MEM_LATENCY`, default 2: cycles from the mem_en cycle to the ready cycle. Legal range 1..15.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch requests an instruction read; held until `if_ready`.
- `if_addr`  in  32  fetch byte address (the current PC).
- `if_rdata`  out  32  instruction word; valid when `if_ready`=1, held until the next fetch completion.
- `if_ready`  out  1  one-cycle pulse marking fetch completion.
- `dm_req`  in  1  memory stage requests an access; held until `dm_ready`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  32  data byte address.
- `dm_wdata`  in  32  store data.
- `dm_rdata`  out  32  load data; valid when `dm_ready`=1, held otherwise.
- `dm_ready`  out  1  one-cycle pulse marking data completion.
- `mem_en`  out  1  one-cycle access strobe to the backing memory.
- `mem_we`  out  1  write strobe; only ever high together with `mem_en`.
- `mem_addr`  out  32  latched access address.
- `mem_wdata`  out  32  latched store data.
- `mem_rdata`  in  32  memory read data; valid in cycle A+MEM_LATENCY-1.
- `stall_f`  out  1  `if_req & ~if_ready`, combinational.
- `stall_m`  out  1  `dm_req & ~dm_ready`, combinational.

## Operation

**States:** IDLE, ISSUE, WAIT, RESP.

**Registers:**
- `owner`: IF or DM.
- `last_grant`: IF or DM.
- `cnt`: 4 bits.
- Latched address, we and wdata.
- Two rdata registers.

**IDLE:**
- No request pending: stay in IDLE.
- Only one request pending: grant it.
- Both pending: grant the requester that is not `last_grant`.
- On a grant:
  - latch addr/we/wdata from the granted requester;
  - set `owner` and `last_grant` to it;
  - set `cnt` = MEM_LATENCY-1;
  - go to ISSUE.

**ISSUE (cycle A):**
- `mem_en`=1; `mem_we` = latched we.
- If `cnt`==0, go to RESP; otherwise go to WAIT.
- Sample `mem_rdata` into the owner's rdata register at the end of whichever cycle is A+MEM_LATENCY-1. With MEM_LATENCY=1 that is ISSUE itself.

**WAIT:**
- `mem_en`=0.
- Decrement `cnt`; when `cnt`==1, go to RESP.
- Capture `mem_rdata` on the exit edge, for reads only.

**RESP:**
- Pulse the owner's ready.
- Go to IDLE unconditionally.

**Rules:**
- Stores never modify `dm_rdata`.
- `mem_addr` and `mem_wdata` hold their latched values outside ISSUE. They are 0 after reset.
- Requester inputs are ignored outside IDLE. A mid-transaction change of address or data has no effect, and a dropped request still completes with a ready pulse.
- `if_ready` and `dm_ready` are never high in the same cycle.

**Reset (`reset_n`=0):** takes effect immediately, including mid-transaction, with no ready pulse and no further mem_en.
- State = IDLE.
- All outputs 0, except `stall_f`/`stall_m`, which follow their equations.
- rdata registers = 0.
- `last_grant` = IF, so data wins the first simultaneous contention.

## Timing

- Request seen in IDLE at cycle T: `mem_en` in T+1 and ready pulse in T+1+MEM_LATENCY. With the default latency, ready is at T+3.
- The stall for that access is high from T through T+MEM_LATENCY.
- Minimum spacing between grants: MEM_LATENCY+2 cycles, since RESP→IDLE costs one cycle.
- A requester that keeps its request high after ready is treated as a new request in the following IDLE cycle.
- Every output is registered, except `stall_f` and `stall_m`.

## Test plan

- **Reset:** hold `reset_n`=0 with both requests high → `mem_en`=`mem_we`=`if_ready`=`dm_ready`=0, rdata=0, `stall_f`=`stall_m`=1. After release, DM is granted first.
- **Single fetch, MEM_LATENCY=2:** `if_req` at T with `if_addr`=0x00400000 and memory returning 0x20080005 → `mem_en`=1 only in T+1 with `mem_addr`=0x00400000; `if_ready` pulses at T+3 with `if_rdata`=0x20080005; `stall_f` is high for T..T+2.
- **Contention:** both requests held continuously from reset for four grants → grant order DM, IF, DM, IF. Ready pulses at cycles 3, 7, 11, 15 relative to the first IDLE cycle, and never overlap.
- **Store:** `dm_we`=1, `dm_addr`=0x10010004, `dm_wdata`=0xDEADBEEF → `mem_we`=`mem_en`=1 for exactly one cycle with that addr/data; `dm_ready` pulses; `dm_rdata` keeps its prior value.
- **MEM_LATENCY=1 build:** back-to-back loads → ready 2 cycles after each request. Data is captured from `mem_rdata` in the ISSUE cycle; grants are 3 cycles apart.
- **Reset mid-operation:** assert `reset_n`=0 in WAIT → `mem_en`=0 at once and no ready pulse. A request after release starts with a fresh ISSUE.
